// File: rtl/line_frame_pkg.sv
// Shared types and constants for the paired-line frame transmitter.
// Line encodings are packed as {line1, line2}.
package line_frame_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } state_t;

    localparam int unsigned PHASE_W   = 2;
    localparam int unsigned FRAME_LEN = 4;

    localparam logic [1:0] LINE_BIT1 = 2'b11;
    localparam logic [1:0] LINE_BIT0 = 2'b10;
    localparam logic [1:0] LINE_IDLE = 2'b00;

    function automatic logic [1:0] line_code(input logic b);
        return b ? LINE_BIT1 : LINE_BIT0;
    endfunction

endpackage

// File: rtl/line_frame_fifo.sv
// Power-of-two word FIFO feeding the frame transmitter.
// The caller guarantees push only when not full and pop only when not empty.
module line_frame_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               wr_data,
    output logic [3:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/line_frame_tx.sv
// Sends one 4-phase frame per 4 cycles on a line pair: payload frames from the
// FIFO when a word is queued at the frame boundary, idle frames otherwise.
module line_frame_tx
    import line_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [3:0]               in_data,
    output logic                     in_ready,
    output logic                     line1,
    output logic                     line2,
    output logic                     frame_start,
    output logic [1:0]               phase,
    output logic                     idle_frame,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [3:0]           sreg_q, sreg_d;
    logic                 started_q;
    logic [1:0]           line_d;
    logic                 frame_edge;
    logic                 data_bit;
    logic                 push;
    logic                 pop;
    logic [3:0]           head;

    assign in_ready = started_q && (fifo_count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign phase    = phase_q;

    line_frame_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .head    (head),
        .count   (fifo_count)
    );

    // The first edge after reset has no previous frame to finish, so it opens
    // phase 0 directly instead of advancing the counter.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q + 1'b1;
        sreg_d     = sreg_q >> 1;
        pop        = 1'b0;
        data_bit   = sreg_q[0];
        frame_edge = !started_q || (phase_q == PHASE_W'(FRAME_LEN - 1));
        if (frame_edge) begin
            phase_d = '0;
            if (fifo_count != '0) begin
                pop      = 1'b1;
                state_d  = ST_DATA;
                sreg_d   = {1'b0, head[3:1]};
                data_bit = head[0];
            end else begin
                state_d  = ST_IDLE;
                sreg_d   = '0;
            end
        end
        line_d = (state_d == ST_DATA) ? line_code(data_bit) : LINE_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            sreg_q      <= '0;
            started_q   <= 1'b0;
            line1       <= 1'b0;
            line2       <= 1'b0;
            frame_start <= 1'b0;
            idle_frame  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sreg_q      <= sreg_d;
            started_q   <= 1'b1;
            line1       <= line_d[1];
            line2       <= line_d[0];
            frame_start <= frame_edge;
            idle_frame  <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_line_frame_tx.sv
// Directed bench for line_frame_tx: idle frames, payload encoding, FIFO full,
// push/pop collisions and asynchronous reset mid-frame.
module tb_line_frame_tx;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       line1;
    logic       line2;
    logic       frame_start;
    logic [1:0] phase;
    logic       idle_frame;
    logic [2:0] fifo_count;

    int vectors;
    int miscompares;

    line_frame_tx #(
        .DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .line1       (line1),
        .line2       (line2),
        .frame_start (frame_start),
        .phase       (phase),
        .idle_frame  (idle_frame),
        .fifo_count  (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Leaves reset released between edges; the next edge opens the first frame.
    task automatic do_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
        tick();
        vectors++;
        if ({line1, line2, frame_start, idle_frame, phase} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", {line1, line2, frame_start, idle_frame, phase}, 6'b000000);
        end
        vectors++;
        if ({in_ready, fifo_count} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_fifo: got ready/count %b want %b", {in_ready, fifo_count}, 4'b0000);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        vectors++;
        if ({in_ready, fifo_count, frame_start} !== 5'b10001) begin
            miscompares++;
            $display("FAIL reset_release: got ready/count/fs %b want %b", {in_ready, fifo_count, frame_start}, 5'b10001);
        end
    endtask

    task automatic test_idle_frames;
        logic [5:0] exp;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = {2'b00, (c == 1 || c == 5), 1'b1, 2'(c - 1)};
            vectors++;
            if ({line1, line2, frame_start, idle_frame, phase} !== exp) begin
                miscompares++;
                $display("FAIL idle_frames c%0d: got %b want %b", c, {line1, line2, frame_start, idle_frame, phase}, exp);
            end
        end
    endtask

    task automatic test_single_word;
        logic [3:0] w;
        logic [5:0] exp;
        w = 4'b1010;
        do_reset();
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({fifo_count, idle_frame, phase} !== {3'd1, 1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL single_push: got count/idle/phase %b want %b", {fifo_count, idle_frame, phase}, {3'd1, 1'b1, 2'd3});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = {1'b1, w[k], (k == 0), 1'b0, 2'(k)};
            vectors++;
            if ({line1, line2, frame_start, idle_frame, phase} !== exp) begin
                miscompares++;
                $display("FAIL single_frame p%0d: got %b want %b", k, {line1, line2, frame_start, idle_frame, phase}, exp);
            end
        end
        vectors++;
        if (fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_drain: got count %0d want 0", fifo_count);
        end
        tick();
        vectors++;
        if ({line1, line2, frame_start, idle_frame} !== 4'b0011) begin
            miscompares++;
            $display("FAIL single_after: got %b want %b", {line1, line2, frame_start, idle_frame}, 4'b0011);
        end
    endtask

    task automatic test_fifo_full;
        logic [3:0] words [5];
        logic [5:0] exp;
        words = '{4'b0011, 4'b0101, 4'b1100, 4'b1001, 4'b1111};
        do_reset();
        for (int c = 1; c <= 4; c++) tick();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = words[i];
            tick();
            vectors++;
            if ({fifo_count, in_ready, idle_frame} !== {3'(i + 1), (i != 3), 1'b1}) begin
                miscompares++;
                $display("FAIL full_fill %0d: got count/ready/idle %b want %b", i, {fifo_count, in_ready, idle_frame}, {3'(i + 1), (i != 3), 1'b1});
            end
        end
        in_data = words[4];
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                if (f == 0 && k == 0) begin
                    in_valid = 1'b0;
                    vectors++;
                    if ({fifo_count, in_ready} !== {3'd3, 1'b1}) begin
                        miscompares++;
                        $display("FAIL full_pop_edge: got count/ready %b want %b", {fifo_count, in_ready}, {3'd3, 1'b1});
                    end
                end
                exp = {1'b1, words[f][k], (k == 0), 1'b0, 2'(k)};
                vectors++;
                if ({line1, line2, frame_start, idle_frame, phase} !== exp) begin
                    miscompares++;
                    $display("FAIL full_frame f%0d p%0d: got %b want %b", f, k, {line1, line2, frame_start, idle_frame, phase}, exp);
                end
            end
        end
        tick();
        vectors++;
        if ({line1, line2, frame_start, idle_frame, fifo_count} !== {4'b0011, 3'd0}) begin
            miscompares++;
            $display("FAIL full_fifth_dropped: got %b want %b", {line1, line2, frame_start, idle_frame, fifo_count}, {4'b0011, 3'd0});
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] words [2];
        logic [5:0] exp;
        words = '{4'b0110, 4'b1001};
        do_reset();
        tick();
        in_valid = 1'b1;
        in_data  = words[0];
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = words[1];
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                in_valid = 1'b0;
                if (k == 0) begin
                    vectors++;
                    if (fifo_count !== 3'(1 - f)) begin
                        miscompares++;
                        $display("FAIL b2b_count f%0d: got %0d want %0d", f, fifo_count, 1 - f);
                    end
                end
                exp = {1'b1, words[f][k], (k == 0), 1'b0, 2'(k)};
                vectors++;
                if ({line1, line2, frame_start, idle_frame, phase} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_frame f%0d p%0d: got %b want %b", f, k, {line1, line2, frame_start, idle_frame, phase}, exp);
                end
            end
        end
        tick();
        vectors++;
        if ({line1, line2, idle_frame} !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_after: got %b want 001", {line1, line2, idle_frame});
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [5:0] exp;
        do_reset();
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(i + 5);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if ({phase, line1, idle_frame, fifo_count} !== {2'd2, 1'b1, 1'b0, 3'd3}) begin
            miscompares++;
            $display("FAIL midrst_setup: got %b want %b", {phase, line1, idle_frame, fifo_count}, {2'd2, 1'b1, 1'b0, 3'd3});
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({line1, line2, frame_start, idle_frame, phase, fifo_count, in_ready} !== 10'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want %b", {line1, line2, frame_start, idle_frame, phase, fifo_count, in_ready}, 10'b0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = {2'b00, (c == 1 || c == 5), 1'b1, 2'(c - 1)};
            vectors++;
            if ({line1, line2, frame_start, idle_frame, phase} !== exp || fifo_count !== 3'd0) begin
                miscompares++;
                $display("FAIL midrst_after c%0d: got %b count %0d want %b count 0", c, {line1, line2, frame_start, idle_frame, phase}, fifo_count, exp);
            end
        end
    endtask

    task automatic test_push_on_empty_pop;
        logic [3:0] w;
        logic [5:0] exp;
        w = 4'b0111;
        do_reset();
        for (int c = 1; c <= 4; c++) tick();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({line1, line2, frame_start, idle_frame, fifo_count} !== {4'b0011, 3'd1}) begin
            miscompares++;
            $display("FAIL empty_pop_edge: got %b want %b", {line1, line2, frame_start, idle_frame, fifo_count}, {4'b0011, 3'd1});
        end
        tick();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = {1'b1, w[k], (k == 0), 1'b0, 2'(k)};
            vectors++;
            if ({line1, line2, frame_start, idle_frame, phase} !== exp) begin
                miscompares++;
                $display("FAIL empty_pop_next p%0d: got %b want %b", k, {line1, line2, frame_start, idle_frame, phase}, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        test_reset();
        test_idle_frames();
        test_single_word();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_push_on_empty_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_frame_tx.md
LINE_FRAME_TX -- requirements
Module: line_frame_tx

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries in the input FIFO (power of two, 2..16).
REQ-002 Port clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  SHALL indicate in_data holds a word to enqueue.
REQ-005 Port in_data  input  4  SHALL carry one frame payload; bit k is sent in phase k.
REQ-006 Port in_ready  output  1  SHALL be high when the FIFO can accept a word (count < DEPTH).
REQ-007 Port line1  output  1  SHALL carry the first line of the pair, registered.
REQ-008 Port line2  output  1  SHALL carry the second line of the pair, registered.
REQ-009 Port frame_start  output  1  SHALL be high during phase 0 of every frame, registered.
REQ-010 Port phase  output  2  SHALL give the phase (0..3) of the currently driven line values.
REQ-011 Port idle_frame  output  1  SHALL be high for all 4 cycles of a frame that carries no FIFO word.
REQ-012 Port fifo_count  output  $clog2(DEPTH)+1  SHALL give the current FIFO occupancy.

Function
REQ-013 A frame SHALL last exactly 4 cycles (phases 0,1,2,3); frames SHALL follow back-to-back with no gap.
REQ-014 The phase counter SHALL wrap 3 -> 0 and SHALL advance on every clock edge outside reset.
REQ-015 The FSM SHALL have states ST_IDLE (sending idle frame) and ST_DATA (sending payload frame); state SHALL be re-decided only at the edge that starts phase 0.
REQ-016 At a phase-0 edge: FIFO non-empty -> pop head into a 4-bit shift register, go ST_DATA; FIFO empty -> go ST_IDLE.
REQ-017 In ST_DATA phase k: payload bit 1 SHALL drive line1=1,line2=1; payload bit 0 SHALL drive line1=1,line2=0.
REQ-018 In ST_IDLE, line1 and line2 SHALL both be 0 for all 4 phases, and idle_frame SHALL be 1.
REQ-019 A push SHALL occur on an edge where in_valid && in_ready; in_data SHALL be sampled on that edge.
REQ-020 in_ready SHALL depend only on registered fifo_count; when full, in_ready SHALL be 0 even on a pop edge.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; the popped word SHALL be the older head.
REQ-022 A word pushed on the same edge as a pop from an empty FIFO SHALL NOT be sent in that frame; that frame SHALL be idle.
REQ-023 Words SHALL be sent in strict FIFO order, each exactly once; in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While reset is high: line1=0, line2=0, frame_start=0, idle_frame=0, phase=0, fifo_count=0, in_ready=0, state=ST_IDLE, FIFO emptied.
REQ-026 The first rising edge after reset release SHALL begin phase 0 of the first frame (frame_start=1).
REQ-027 Reset asserted mid-frame SHALL force all outputs to reset values immediately and discard the partial frame and all queued words.

Structure
REQ-028 Package line_frame_pkg SHALL hold the state enum, the phase width (2), the frame length (4), and the line encodings for bit-1, bit-0 and idle.
REQ-029 The FIFO SHALL be a separate sub-module line_frame_fifo (parameter DEPTH, push/pop/count/head interface); the FSM, phase counter and shift register SHALL stay in line_frame_tx.

Verification
REQ-030 Reset, then idle 8 cycles -> two idle frames: lines (0,0) throughout, idle_frame=1, frame_start high on cycles 1 and 5.
REQ-031 Push 4'b1010 while in phase 2 of an idle frame -> next frame phases 0..3 drive (1,0),(1,1),(1,0),(1,1), idle_frame=0, fifo_count returns 0.
REQ-032 Push 5 words with in_valid held and no pop -> 4 accepted, in_ready=0 at fifo_count=4, 5th word never appears on the lines.
REQ-033 Push on the same edge as a phase-0 pop with one word queued -> fifo_count stays 1, words sent in push order on consecutive frames.
REQ-034 Assert reset during phase 2 of a data frame with 3 words queued -> lines (0,0) and fifo_count=0 at once; after release, first frame is idle.
REQ-035 Push into empty FIFO exactly on a phase-0 edge -> that frame is idle, word sent in the following frame.
